// File: rtl/exec_monitor_if.sv
// Signal bundle between the CPU core / front panel and the run-control and
// statistics stage. The master side drives decode, button and operand
// signals. The slave side (exec_monitor) returns the execute enable and
// the display statistics.
interface exec_monitor_if #(
   parameter int unsigned CNT_W = 16
);
   logic              tick;
   logic              step_mode;
   logic              go;
   logic              is_j;
   logic              is_br;
   logic              br_taken;
   logic              is_syscall;
   logic [31:0]       v0;
   logic [31:0]       a0;
   logic              cpu_en;
   logic              halted;
   logic [31:0]       total_cycle;
   logic [CNT_W-1:0]  unconditional;
   logic [CNT_W-1:0]  conditional;
   logic [CNT_W-1:0]  conditionalsucces;
   logic [31:0]       syscall_out;

   modport master (
      output tick, step_mode, go, is_j, is_br, br_taken, is_syscall, v0, a0,
      input  cpu_en, halted, total_cycle, unconditional, conditional,
             conditionalsucces, syscall_out
   );

   modport slave (
      input  tick, step_mode, go, is_j, is_br, br_taken, is_syscall, v0, a0,
      output cpu_en, halted, total_cycle, unconditional, conditional,
             conditionalsucces, syscall_out
   );
endinterface

// File: rtl/exec_monitor.sv
// Run-control and statistics stage beside the single-cycle CPU core.
// This block gates the core's execute enable in three ways: free run,
// single-step on the go button, or halt on the exit syscall.
// It also counts retired instructions, jumps, branches and taken branches,
// and it latches the print-syscall argument for the seven-segment display.
module exec_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter logic [31:0] HALT_CODE   = 32'h0000_000A,
   parameter logic [31:0] PRINT_CODE  = 32'h0000_0022,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   exec_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      ARMED = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [SYNC_STAGES-1:0]  go_sync;
   logic                    go_prev;
   logic                    go_rise;
   logic                    exec;
   logic                    halt_hit;
   logic                    print_hit;
   logic [31:0]             total_q;
   logic [31:0]             sys_q;
   logic [CNT_W-1:0]        unc_q;
   logic [CNT_W-1:0]        cond_q;
   logic [CNT_W-1:0]        succ_q;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                    input logic            en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   function automatic logic [31:0] sat_inc_32(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   // Instructions retire only in RUN or ARMED, one per tick. The enable is
   // also forced low while reset is held, so the core cannot write state
   // during reset.
   assign exec       = ((state == RUN) || (state == ARMED)) && bus.tick;
   assign bus.cpu_en = exec && rst;
   assign halt_hit   = exec && bus.is_syscall && (bus.v0 == HALT_CODE);
   assign print_hit  = exec && bus.is_syscall && (bus.v0 == PRINT_CODE);
   assign go_rise    = go_sync[SYNC_STAGES-1] && !go_prev;

   // Synchronize the raw go button and keep one cycle of history for the rising-edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         go_sync <= '0;
         go_prev <= 1'b0;
      end else begin
         // NOTE: registers update with <= so every flop samples pre-edge values; blocking here would collapse the synchronizer chain.
         go_sync <= {go_sync[SYNC_STAGES-2:0], bus.go};
         go_prev <= go_sync[SYNC_STAGES-1];
      end
   end

   // Run-control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   // Next-state logic: halt outranks every stepping transition.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         RUN: begin
            if (halt_hit)                   state_nxt = HALT;
            else if (bus.step_mode && exec) state_nxt = PAUSE;
         end
         PAUSE: begin
            if (!bus.step_mode) state_nxt = RUN;
            else if (go_rise)   state_nxt = ARMED;
         end
         ARMED: begin
            if (halt_hit)  state_nxt = HALT;
            else if (exec) state_nxt = bus.step_mode ? PAUSE : RUN;
         end
         HALT: begin
            if (go_rise) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Saturating statistics and print latch, advanced only on retiring edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_q <= '0;
         unc_q   <= '0;
         cond_q  <= '0;
         succ_q  <= '0;
         sys_q   <= '0;
      end else if (exec) begin
         total_q <= sat_inc_32(total_q, 1'b1);
         unc_q   <= sat_inc_cnt(unc_q, bus.is_j);
         cond_q  <= sat_inc_cnt(cond_q, bus.is_br);
         succ_q  <= sat_inc_cnt(succ_q, bus.is_br && bus.br_taken);
         if (print_hit) sys_q <= bus.a0;
      end
   end

   assign bus.halted            = (state == HALT);
   assign bus.total_cycle       = total_q;
   assign bus.unconditional     = unc_q;
   assign bus.conditional       = cond_q;
   assign bus.conditionalsucces = succ_q;
   assign bus.syscall_out       = sys_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Scoreboard bench for exec_monitor. Each instruction the bench expects to
// retire pushes the predicted register state after that edge into a queue.
// The monitor process pops one entry per observed cpu_en pulse and compares it.
module tb_exec_monitor;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned SYNC_STAGES = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exec_monitor_if #(.CNT_W(CNT_W)) bus ();

   exec_monitor #(
      .CNT_W      (CNT_W),
      .HALT_CODE  (32'h0000_000A),
      .PRINT_CODE (32'h0000_0022),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [31:0]      total;
      logic [CNT_W-1:0] unc;
      logic [CNT_W-1:0] cond;
      logic [CNT_W-1:0] succ;
      logic [31:0]      sys;
      logic             halted;
   } exp_t;

   exp_t exp_q[$];
   exp_t model;
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] frozen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t step_model(input exp_t m, input bit j, input bit br, input bit tk,
                                       input bit sc, input logic [31:0] v0);
      exp_t r = m;
      if (r.total != '1) r.total = r.total + 1;
      if (j  && r.unc  != '1) r.unc  = r.unc + 1'b1;
      if (br && r.cond != '1) r.cond = r.cond + 1'b1;
      if (br && tk && r.succ != '1) r.succ = r.succ + 1'b1;
      if (sc && v0 == 32'h0000_000A) r.halted = 1'b1;
      return r;
   endfunction

   // Monitor: a cpu_en seen at a falling edge means the following rising
   // edge retires an instruction, so the next falling edge compares.
   initial begin : monitor
      bit pend;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend && rst) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_exec: got cpu_en pulse, expected none (t=%0t)", $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_total",  bus.total_cycle,              mon_e.total);
               check("sb_unc",    32'(bus.unconditional),       32'(mon_e.unc));
               check("sb_cond",   32'(bus.conditional),         32'(mon_e.cond));
               check("sb_succ",   32'(bus.conditionalsucces),   32'(mon_e.succ));
               check("sb_sys",    bus.syscall_out,              mon_e.sys);
               check("sb_halted", 32'(bus.halted),              32'(mon_e.halted));
            end
         end
         pend = rst && bus.cpu_en;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic idle_inputs();
      bus.tick       = 1'b0;
      bus.is_j       = 1'b0;
      bus.is_br      = 1'b0;
      bus.br_taken   = 1'b0;
      bus.is_syscall = 1'b0;
      bus.v0         = 32'h0;
      bus.a0         = 32'h0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One retiring instruction: drives a one-cycle tick with the given decode fields.
   task automatic exec_instr(input bit j, input bit br, input bit tk, input bit sc,
                             input logic [31:0] v0, input logic [31:0] a0);
      model = step_model(model, j, br, tk, sc, v0);
      if (sc && v0 == 32'h0000_0022) model.sys = a0;
      exp_q.push_back(model);
      bus.tick       = 1'b1;
      bus.is_j       = j;
      bus.is_br      = br;
      bus.br_taken   = tk;
      bus.is_syscall = sc;
      bus.v0         = v0;
      bus.a0         = a0;
      cycles(1);
      idle_inputs();
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         cycles(1);
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cpu_en"}, 32'(bus.cpu_en),            32'h0);
      check({tag, "_halted"}, 32'(bus.halted),            32'h0);
      check({tag, "_total"},  bus.total_cycle,            32'h0);
      check({tag, "_unc"},    32'(bus.unconditional),     32'h0);
      check({tag, "_cond"},   32'(bus.conditional),       32'h0);
      check({tag, "_succ"},   32'(bus.conditionalsucces), 32'h0);
      check({tag, "_sys"},    bus.syscall_out,            32'h0);
   endtask

   task automatic do_reset();
      drain("pre_reset_drain", 20);
      rst = 1'b0;
      #1;
      check_all_zero("reset");
      model = '0;
      exp_q.delete();
      cycles(1);
      rst = 1'b1;
      cycles(1);
   endtask

   initial begin : stimulus
      rst           = 1'b0;
      bus.step_mode = 1'b0;
      bus.go        = 1'b0;
      idle_inputs();
      model = '0;
      cycles(2);
      check_all_zero("por");
      rst = 1'b1;
      cycles(1);

      // Five conditional branches, taken pattern 1,0,1,0,1.
      for (int i = 0; i < 5; i++) exec_instr(1'b0, 1'b1, (i % 2) == 0, 1'b0, 32'h0, 32'h0);
      drain("br_drain", 10);
      check("br_total", bus.total_cycle,                5);
      check("br_cond",  32'(bus.conditional),           5);
      check("br_succ",  32'(bus.conditionalsucces),     3);
      check("br_unc",   32'(bus.unconditional),         0);
      // br_taken alone is ignored; an illegal j+br+taken still counts each field.
      exec_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      exec_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      drain("mix_drain", 10);

      // Print syscall, then a syscall with an unrelated code.
      exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0022, 32'hDEAD_BEEF);
      exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h1234_5678);
      drain("sys_drain", 10);
      check("sys_out",    bus.syscall_out,  32'hDEAD_BEEF);
      check("sys_run",    32'(bus.halted),  0);

      // Exit syscall halts; ticks while halted must not retire.
      exec_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 32'h0);
      drain("halt_drain", 10);
      check("halt_flag", 32'(bus.halted), 1);
      frozen = model.total;
      for (int i = 0; i < 10; i++) begin
         bus.tick = 1'b1;
         #1;
         check("halt_cpu_en", 32'(bus.cpu_en), 0);
         cycles(1);
         bus.tick = 1'b0;
         cycles(1);
      end
      check("halt_frozen", bus.total_cycle, frozen);
      bus.go = 1'b1;
      for (int c = 0; c < SYNC_STAGES + 2; c++) begin
         cycles(1);
         if (!bus.halted) break;
      end
      check("halt_resume", 32'(bus.halted), 0);
      model.halted = 1'b0;
      bus.go = 1'b0;
      cycles(4);
      exec_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drain("resume_drain", 10);
      check("resume_total", bus.total_cycle, frozen + 1);

      // go in RUN is ignored: the next tick still retires.
      bus.go = 1'b1;
      cycles(4);
      bus.go = 1'b0;
      cycles(4);
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drain("run_go_drain", 10);

      // Single-step: one pulse entering step mode, then one per go press.
      do_reset();
      model = step_model(model, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(model);
      bus.step_mode = 1'b1;
      bus.tick      = 1'b1;
      cycles(6);
      drain("step_first", 4);
      for (int p = 0; p < 3; p++) begin
         model = step_model(model, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         exp_q.push_back(model);
         bus.go = 1'b1;
         cycles(4);
         bus.go = 1'b0;
         cycles(4);
      end
      drain("step_drain", 10);
      check("step_total", bus.total_cycle, 4);

      // Asynchronous reset while ARMED with a tick in flight.
      bus.tick = 1'b0;
      bus.go   = 1'b1;
      cycles(5);
      bus.go = 1'b0;
      cycles(3);
      bus.tick = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("armed_rst");
      bus.tick      = 1'b0;
      bus.step_mode = 1'b0;
      model = '0;
      exp_q.delete();
      cycles(2);
      rst = 1'b1;
      cycles(1);
      exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drain("post_rst_run", 10);

      // Saturation: 65538 jumps hold the jump counter at all-ones.
      do_reset();
      for (int i = 0; i < 65538; i++) begin
         model = step_model(model, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         exp_q.push_back(model);
      end
      bus.is_j = 1'b1;
      bus.tick = 1'b1;
      cycles(65538);
      idle_inputs();
      drain("sat_drain", 10);
      check("sat_unc",   32'(bus.unconditional), 32'h0000_FFFF);
      check("sat_total", bus.total_cycle,        32'd65538);

      cycles(3);
      check("final_queue", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
